fft_stage_ctrl: RTL and testbench
=================================

FFT_STAGE_CTRL -- requirements
Module: fft_stage_ctrl

Interface
REQ-001 SHALL have parameter N_LOG2, default 3, meaning log2 of FFT size N (N=8 default).
REQ-002 SHALL have parameter BF_LAT, default 4, meaning cycles from rd_en pulse to matching butterfly result (memory read plus butterfly pipeline), legal range 2..15.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  request to run one complete FFT, sampled in IDLE only.
REQ-006 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-007 SHALL have port done  output  1  one-cycle pulse after the final write.
REQ-008 SHALL have port rd_en  output  1  read strobe for both butterfly operands.
REQ-009 SHALL have ports rd_addr0, rd_addr1  output  N_LOG2 each  operand addresses for in_x0 and in_x1, valid with rd_en.
REQ-010 SHALL have port tw_addr  output  N_LOG2-1  twiddle ROM index for w, valid with rd_en.
REQ-011 SHALL have port bf_sync  output  1  high in the rd_en cycle; drives the butterfly phase counter so it aligns with issue.
REQ-012 SHALL have port wr_en  output  1  write-back strobe for out_x0/out_x1.
REQ-013 SHALL have ports wr_addr0, wr_addr1  output  N_LOG2 each  write-back addresses, valid with wr_en.
REQ-014 SHALL have port stage  output  N_LOG2 bits wide (clog2 of N_LOG2+1 minimum)  index of current stage, for debug.

Function
REQ-015 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-016 IDLE -> ISSUE on start=1; first rd_en in the cycle after start is sampled; stage=0, butterfly index b=0.
REQ-017 In ISSUE, SHALL pulse rd_en/bf_sync every second cycle (initiation interval 2), N/2 pulses per stage, b incremented per pulse.
REQ-018 Addresses for stage s, butterfly b: span=2^s, pos=b mod span, grp=b>>s; rd_addr0=(grp<<(s+1))|pos; rd_addr1=rd_addr0+span; tw_addr=pos<<(N_LOG2-1-s).
REQ-019 SHALL delay rd_addr0/rd_addr1 through a BF_LAT-deep address/valid pipeline; wr_en and wr_addr0/1 appear exactly BF_LAT cycles after the matching rd_en.
REQ-020 After the last issue of a stage, ISSUE -> DRAIN; DRAIN holds until the last write of that stage has occurred (read-after-write protection across stages).
REQ-021 DRAIN -> ISSUE (stage+1, b=0) in the cycle after the last write if stage<N_LOG2-1, first rd_en in that cycle; else DRAIN -> DONE.
REQ-022 DONE SHALL pulse done for one cycle, deassert busy in the same cycle, then go to IDLE.
REQ-023 Stage period SHALL be N+BF_LAT-1 cycles; done SHALL occur 1+N_LOG2*(N+BF_LAT-1) cycles after the start-sampling cycle.
REQ-024 start while busy SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-025 rd_en and wr_en SHALL never be high for the same address in the same cycle; outputs other than strobes SHALL hold last value when strobe low.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, clear the address pipeline, and drive busy, done, rd_en, bf_sync, wr_en, all addresses, tw_addr and stage to 0.
REQ-027 Reset mid-FFT SHALL discard all pending writes; no wr_en after rst_n rises until a new start.

Configuration
REQ-028 Macro FFT_STAGE_CTRL_ABORT_EN: when defined, SHALL add input abort (1 bit); abort=1 in any non-IDLE state SHALL, next edge, return to IDLE, clear the address pipeline, drop busy, and not pulse done; abort in IDLE is ignored.
REQ-029 Without FFT_STAGE_CTRL_ABORT_EN, the abort port SHALL not exist and only reset terminates an FFT.

Verification (N_LOG2=3, BF_LAT=4)
REQ-030 start at cycle 0 -> rd_en at cycles 1,3,5,7 with (addr0,addr1,tw) = (0,1,0),(2,3,0),(4,5,0),(6,7,0); wr_en at 5,7,9,11 with same addresses.
REQ-031 Stage 1 -> rd_en at 12,14,16,18 with (0,2,0),(1,3,2),(4,6,0),(5,7,2); stage 2 at 23.. with (0,4,0),(1,5,1),(2,6,2),(3,7,3).
REQ-032 Full run -> done single pulse at cycle 34, busy high cycles 1..33, exactly 12 wr_en pulses total.
REQ-033 start held high continuously -> second FFT begins rd_en at cycle 36 (start resampled in IDLE at 35), no overlap with first.
REQ-034 rst_n low at cycle 15 -> all outputs 0 asynchronously, no wr_en at 16..19, busy stays 0 until next start.
REQ-035 With FFT_STAGE_CTRL_ABORT_EN, abort at cycle 20 -> IDLE at 21, no done, no wr_en after cycle 20; start at 22 runs a clean FFT with done at 56.

Source files
------------

// File: rtl/fft_stage_ctrl.sv
// Address and strobe sequencer for a radix-2 in-place FFT: issues N/2 butterflies per stage at II=2
// and writes results back BF_LAT cycles later. Define FFT_STAGE_CTRL_ABORT_EN to add an abort input.
module fft_stage_ctrl #(
   parameter int N_LOG2 = 3,
   parameter int BF_LAT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
`ifdef FFT_STAGE_CTRL_ABORT_EN
   input  logic              abort,
`endif
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [N_LOG2-1:0] rd_addr0,
   output logic [N_LOG2-1:0] rd_addr1,
   output logic [N_LOG2-2:0] tw_addr,
   output logic              bf_sync,
   output logic              wr_en,
   output logic [N_LOG2-1:0] wr_addr0,
   output logic [N_LOG2-1:0] wr_addr1,
   output logic [N_LOG2-1:0] stage
);

   localparam int PD = BF_LAT - 1;
   localparam logic [N_LOG2-1:0] HALF = N_LOG2'(1 << (N_LOG2 - 1));
   localparam logic [N_LOG2-1:0] LAST = N_LOG2'(N_LOG2 - 1);
   localparam logic [N_LOG2-1:0] ONE  = N_LOG2'(1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [N_LOG2-1:0] stage_q, stage_d, b_q, b_d;
   logic              phase_q, phase_d;
   logic              busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d, wr_en_q, wr_en_d;
   logic [N_LOG2-1:0] rd_addr0_q, rd_addr0_d, rd_addr1_q, rd_addr1_d;
   logic [N_LOG2-2:0] tw_q, tw_d;
   logic [N_LOG2-1:0] wr_addr0_q, wr_addr0_d, wr_addr1_q, wr_addr1_d;
   logic [PD-1:0]     vld_q, vld_d;
   logic [N_LOG2-1:0] pa0_q [PD];
   logic [N_LOG2-1:0] pa0_d [PD];
   logic [N_LOG2-1:0] pa1_q [PD];
   logic [N_LOG2-1:0] pa1_d [PD];

   logic              issue, abort_w;
   logic [N_LOG2-1:0] iss_stage, iss_b, span, pos, grp, a0, twf;

`ifdef FFT_STAGE_CTRL_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      stage_d    = stage_q;
      b_d        = b_q;
      phase_d    = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      rd_en_d    = 1'b0;
      rd_addr0_d = rd_addr0_q;
      rd_addr1_d = rd_addr1_q;
      tw_d       = tw_q;
      wr_addr0_d = wr_addr0_q;
      wr_addr1_d = wr_addr1_q;
      issue      = 1'b0;
      iss_stage  = stage_q;
      iss_b      = b_q;

      // Address/valid pipeline: entry i holds the issue made i+1 cycles ago.
      vld_d[0] = rd_en_q;
      pa0_d[0] = rd_addr0_q;
      pa1_d[0] = rd_addr1_q;
      for (int i = 1; i < PD; i++) begin
         vld_d[i] = vld_q[i-1];
         pa0_d[i] = pa0_q[i-1];
         pa1_d[i] = pa1_q[i-1];
      end
      wr_en_d = vld_q[PD-1];
      if (vld_q[PD-1]) begin
         wr_addr0_d = pa0_q[PD-1];
         wr_addr1_d = pa1_q[PD-1];
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_ISSUE;
               busy_d    = 1'b1;
               issue     = 1'b1;
               iss_stage = '0;
               iss_b     = '0;
            end
         end
         S_ISSUE: begin
            if (!phase_q) begin
               issue = 1'b1;
            end else if (b_q == HALF) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // The write in flight is the stage's last once nothing remains behind it.
            if (wr_en_q && vld_q == '0) begin
               if (stage_q == LAST) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d   = S_ISSUE;
                  issue     = 1'b1;
                  iss_stage = stage_q + ONE;
                  iss_b     = '0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      span = ONE << iss_stage;
      pos  = iss_b & (span - ONE);
      grp  = iss_b >> iss_stage;
      a0   = (grp << (iss_stage + ONE)) | pos;
      twf  = pos << (LAST - iss_stage);

      if (issue) begin
         rd_en_d    = 1'b1;
         phase_d    = 1'b1;
         stage_d    = iss_stage;
         b_d        = iss_b + ONE;
         rd_addr0_d = a0;
         rd_addr1_d = a0 | span;
         tw_d       = twf[N_LOG2-2:0];
      end

      if (abort_w && state_q != S_IDLE) begin
         state_d = S_IDLE;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         rd_en_d = 1'b0;
         wr_en_d = 1'b0;
         phase_d = 1'b0;
         vld_d   = '0;
         for (int i = 0; i < PD; i++) begin
            pa0_d[i] = '0;
            pa1_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         stage_q    <= '0;
         b_q        <= '0;
         phase_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_en_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         rd_addr0_q <= '0;
         rd_addr1_q <= '0;
         tw_q       <= '0;
         wr_addr0_q <= '0;
         wr_addr1_q <= '0;
         vld_q      <= '0;
         for (int i = 0; i < PD; i++) begin
            pa0_q[i] <= '0;
            pa1_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         stage_q    <= stage_d;
         b_q        <= b_d;
         phase_q    <= phase_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd_en_q    <= rd_en_d;
         wr_en_q    <= wr_en_d;
         rd_addr0_q <= rd_addr0_d;
         rd_addr1_q <= rd_addr1_d;
         tw_q       <= tw_d;
         wr_addr0_q <= wr_addr0_d;
         wr_addr1_q <= wr_addr1_d;
         vld_q      <= vld_d;
         for (int i = 0; i < PD; i++) begin
            pa0_q[i] <= pa0_d[i];
            pa1_q[i] <= pa1_d[i];
         end
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rd_en    = rd_en_q;
   assign bf_sync  = rd_en_q;
   assign rd_addr0 = rd_addr0_q;
   assign rd_addr1 = rd_addr1_q;
   assign tw_addr  = tw_q;
   assign wr_en    = wr_en_q;
   assign wr_addr0 = wr_addr0_q;
   assign wr_addr1 = wr_addr1_q;
   assign stage    = stage_q;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Bench for fft_stage_ctrl: a schedule model built from the stage/butterfly timing rules,
// checked every cycle, plus literal spot checks. Abort scenario only with FFT_STAGE_CTRL_ABORT_EN.
module tb_fft_stage_ctrl;
   localparam int N_LOG2 = 3;
   localparam int BF_LAT = 4;
   localparam int N      = 1 << N_LOG2;
   localparam int P      = N + BF_LAT - 1;
   localparam int MAXC   = 100;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              busy, done, rd_en, bf_sync, wr_en;
   logic [N_LOG2-1:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1, stage;
   logic [N_LOG2-2:0] tw_addr;

   fft_stage_ctrl #(.N_LOG2(N_LOG2), .BF_LAT(BF_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
`ifdef FFT_STAGE_CTRL_ABORT_EN
      .abort(abort),
`endif
      .busy(busy), .done(done), .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
      .tw_addr(tw_addr), .bf_sync(bf_sync), .wr_en(wr_en), .wr_addr0(wr_addr0),
      .wr_addr1(wr_addr1), .stage(stage)
   );

   // clock / reset
   always #5 clk = ~clk;
   int cyc = 0;
   int base = 0;
   always @(posedge clk) cyc++;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   bit exp_rd [MAXC];
   bit exp_wr [MAXC];
   bit exp_done [MAXC];
   bit exp_busy [MAXC];
   bit exp_zero [MAXC];
   int exp_a0 [MAXC];
   int exp_a1 [MAXC];
   int exp_tw [MAXC];
   int exp_st [MAXC];
   int exp_w0 [MAXC];
   int exp_w1 [MAXC];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc - base, act, exp);
      end
   endtask

   task automatic clear_model();
      for (int r = 0; r < MAXC; r++) begin
         exp_rd[r] = 0; exp_wr[r] = 0; exp_done[r] = 0; exp_busy[r] = 0; exp_zero[r] = 0;
         exp_a0[r] = 0; exp_a1[r] = 0; exp_tw[r] = 0; exp_st[r] = 0; exp_w0[r] = 0; exp_w1[r] = 0;
      end
   endtask

   // One FFT whose start is sampled at cycle c0.
   task automatic plan_fft(input int c0);
      int r, span, pos, grp, a0, d;
      for (int s = 0; s < N_LOG2; s++) begin
         span = 1 << s;
         for (int b = 0; b < N / 2; b++) begin
            pos = b % span;
            grp = b / span;
            a0  = grp * 2 * span + pos;
            r   = c0 + 1 + s * P + 2 * b;
            exp_rd[r] = 1; exp_a0[r] = a0; exp_a1[r] = a0 + span;
            exp_tw[r] = pos * ((N / 2) / span); exp_st[r] = s;
            exp_wr[r + BF_LAT] = 1; exp_w0[r + BF_LAT] = a0; exp_w1[r + BF_LAT] = a0 + span;
         end
      end
      d = c0 + 1 + N_LOG2 * P;
      exp_done[d] = 1;
      for (int r2 = c0 + 1; r2 < d; r2++) exp_busy[r2] = 1;
   endtask

   task automatic cancel_from(input int c);
      for (int r = c; r < MAXC; r++) begin
         exp_rd[r] = 0; exp_wr[r] = 0; exp_done[r] = 0; exp_busy[r] = 0;
      end
   endtask

   // scoreboard compare, every cycle on the falling edge
   int cr;
   always @(negedge clk) begin
      if (chk_on) begin
         cr = cyc - base;
         if (cr >= 0 && cr < MAXC) begin
            chk("rd_en", int'(rd_en), int'(exp_rd[cr]));
            chk("bf_sync", int'(bf_sync), int'(exp_rd[cr]));
            chk("wr_en", int'(wr_en), int'(exp_wr[cr]));
            chk("done", int'(done), int'(exp_done[cr]));
            chk("busy", int'(busy), int'(exp_busy[cr]));
            if (exp_rd[cr]) begin
               chk("rd_addr0", int'(rd_addr0), exp_a0[cr]);
               chk("rd_addr1", int'(rd_addr1), exp_a1[cr]);
               chk("tw_addr", int'(tw_addr), exp_tw[cr]);
               chk("stage", int'(stage), exp_st[cr]);
            end
            if (exp_wr[cr]) begin
               chk("wr_addr0", int'(wr_addr0), exp_w0[cr]);
               chk("wr_addr1", int'(wr_addr1), exp_w1[cr]);
            end
            if (exp_zero[cr])
               chk("zero_outs", int'(rd_addr0 | rd_addr1 | wr_addr0 | wr_addr1 | stage) + int'(tw_addr), 0);
            if (rd_en && wr_en)
               chk("rw_overlap", int'(rd_addr0 == wr_addr0 || rd_addr0 == wr_addr1 ||
                                      rd_addr1 == wr_addr0 || rd_addr1 == wr_addr1), 0);
         end
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      chk_on = 1'b0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      step(); step();
      rst_n = 1'b1;
      step();
   endtask

   int wr_cnt;

   initial begin
      // reset state
      step();
      chk("rst_busy", int'(busy), 0);
      chk("rst_rd_en", int'(rd_en), 0);
      chk("rst_wr_en", int'(wr_en), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_addrs", int'(rd_addr0 | rd_addr1 | wr_addr0 | wr_addr1 | stage) + int'(tw_addr), 0);
      rst_n = 1'b1;
      step();

      // Scenario 1: start held high through the first FFT, second FFT from IDLE resample
      clear_model();
      plan_fft(0);
      plan_fft(35);
      for (int r = 0; r < 36; r++) exp_zero[r] = 0;
      base = cyc; chk_on = 1'b1; wr_cnt = 0;
      for (int r = 0; r < 75; r++) begin
         start = (r <= 35);
         if (r <= 34 && wr_en) wr_cnt++;
         if (r == 1) begin
            chk("s1_rd_c1", int'(rd_en), 1);
            chk("s1_a1_c1", int'(rd_addr1), 1);
         end
         if (r == 14) begin
            chk("s1_a0_c14", int'(rd_addr0), 1);
            chk("s1_a1_c14", int'(rd_addr1), 3);
            chk("s1_tw_c14", int'(tw_addr), 2);
         end
         if (r == 25) begin
            chk("s1_a1_c25", int'(rd_addr1), 5);
            chk("s1_tw_c25", int'(tw_addr), 1);
         end
         if (r == 33) chk("s1_busy_c33", int'(busy), 1);
         if (r == 34) begin
            chk("s1_done_c34", int'(done), 1);
            chk("s1_busy_c34", int'(busy), 0);
         end
         if (r == 35) begin
            chk("s1_done_c35", int'(done), 0);
            chk("s1_wr_count", wr_cnt, 12);
         end
         if (r == 36) chk("s1_rd_c36", int'(rd_en), 1);
         step();
      end
      reset_pulse();

      // Scenario 2: reset mid-FFT at cycle 15, restart at 30
      clear_model();
      plan_fft(0);
      cancel_from(15);
      for (int r = 15; r <= 30; r++) exp_zero[r] = 1;
      plan_fft(30);
      base = cyc; chk_on = 1'b1; wr_cnt = 0;
      for (int r = 0; r < 70; r++) begin
         start = (r == 0 || r == 30);
         rst_n = !(r >= 15 && r <= 17);
         #1;
         if (r >= 16 && r <= 29 && wr_en) wr_cnt++;
         if (r == 15) chk("s2_busy_rst", int'(busy), 0);
         if (r == 30) chk("s2_wr_after_rst", wr_cnt, 0);
         if (r == 31) chk("s2_rd_c31", int'(rd_en), 1);
         step();
      end
      reset_pulse();

`ifdef FFT_STAGE_CTRL_ABORT_EN
      // Scenario 3: abort at cycle 20, clean restart at 22
      clear_model();
      plan_fft(0);
      cancel_from(21);
      plan_fft(22);
      base = cyc; chk_on = 1'b1;
      for (int r = 0; r < 60; r++) begin
         start = (r == 0 || r == 22);
         abort = (r == 20);
         if (r == 21) chk("s3_busy_c21", int'(busy), 0);
         if (r == 56) chk("s3_done_c56", int'(done), 1);
         step();
      end
      abort = 1'b0;
`endif

      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
